// File: rtl/asic_ioring_cfg.sv
// asic_ioring_cfg: configuration sequencer for the IO pad ring.
// Keeps one shadow word per pad. On an apply request it freezes the pads,
// shifts every shadow word into the pad chain (last pad MSB first), strobes
// the chain load, waits a settle interval and then releases the hold.
// Optional feature: define ASIC_IORING_READBACK_EN to add a registered
// shadow readback port (rd_addr / rd_data).
module asic_ioring_cfg #(
  parameter int              NPADS     = 16,
  parameter int              CFGW      = 13,
  parameter int              HOLDCYC   = 8,
  parameter logic [CFGW-1:0] CFG_RESET = 13'h0403
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [$clog2(NPADS)-1:0] cfg_addr,
  input  logic [CFGW-1:0]          cfg_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     ser_data,
  output logic                     ser_shift,
  output logic                     ser_load,
  output logic                     pad_hld_n,
  output logic                     pad_enable
`ifdef ASIC_IORING_READBACK_EN
  ,
  input  logic [$clog2(NPADS)-1:0] rd_addr,
  output logic [CFGW-1:0]          rd_data
`endif
);

  localparam int AW    = $clog2(NPADS);
  localparam int NBITS = NPADS * CFGW;
  localparam int BCW   = $clog2(NBITS + 1);
  localparam int SCW   = $clog2(HOLDCYC + 1);
  localparam int BIW   = (CFGW > 1) ? $clog2(CFGW) : 1;

  localparam logic [BCW-1:0] BIT_LAST    = BCW'(NBITS - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(HOLDCYC - 1);
  localparam logic [AW-1:0]  PAD_TOP     = AW'(NPADS - 1);
  localparam logic [BIW-1:0] BIT_TOP     = BIW'(CFGW - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HOLD    = 3'd1;
  localparam logic [2:0] SHIFT   = 3'd2;
  localparam logic [2:0] LOAD    = 3'd3;
  localparam logic [2:0] SETTLE  = 3'd4;
  localparam logic [2:0] RELEASE = 3'd5;

  logic [2:0]      state_reg, state_next;
  logic [BCW-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [SCW-1:0]  settle_cnt_reg, settle_cnt_next;
  logic            hold_cnt_reg, hold_cnt_next;
  logic [AW-1:0]   pad_ptr_reg, pad_ptr_next;
  logic [BIW-1:0]  bit_ptr_reg, bit_ptr_next;
  logic            ser_data_next;
  logic            wr_en;

  logic [CFGW-1:0] shadow [NPADS];

  // Writes are only taken while idle; out-of-range addresses are dropped.
  assign wr_en = cfg_valid && cfg_ready && (int'(cfg_addr) < NPADS);

  // Sequencer next-state and counters; counters saturate and clear on entry.
  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    hold_cnt_next   = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = HOLD;
          hold_cnt_next = 1'b0;
        end
      end
      HOLD: begin
        if (hold_cnt_reg) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
        end else begin
          hold_cnt_next = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt_reg == BIT_LAST) begin
          state_next = LOAD;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      LOAD: begin
        state_next      = SETTLE;
        settle_cnt_next = '0;
      end
      SETTLE: begin
        if (settle_cnt_reg == SETTLE_LAST) begin
          state_next = RELEASE;
        end else begin
          settle_cnt_next = settle_cnt_reg + 1'b1;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stream pointer: points at the bit that goes out on the next shift cycle.
  always_comb begin
    pad_ptr_next  = pad_ptr_reg;
    bit_ptr_next  = bit_ptr_reg;
    ser_data_next = 1'b0;
    if (state_next == SHIFT) begin
      ser_data_next = shadow[pad_ptr_reg][bit_ptr_reg];
      if (bit_ptr_reg == '0) begin
        bit_ptr_next = BIT_TOP;
        if (pad_ptr_reg != '0) begin
          pad_ptr_next = pad_ptr_reg - 1'b1;
        end
      end else begin
        bit_ptr_next = bit_ptr_reg - 1'b1;
      end
    end else if (state_reg == IDLE) begin
      pad_ptr_next = PAD_TOP;
      bit_ptr_next = BIT_TOP;
    end
  end

  // State, counters and registered outputs (decoded from the next state).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      settle_cnt_reg <= '0;
      hold_cnt_reg   <= 1'b0;
      pad_ptr_reg    <= PAD_TOP;
      bit_ptr_reg    <= BIT_TOP;
      cfg_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      ser_data       <= 1'b0;
      ser_shift      <= 1'b0;
      ser_load       <= 1'b0;
      pad_hld_n      <= 1'b0;
      pad_enable     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      settle_cnt_reg <= settle_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      pad_ptr_reg    <= pad_ptr_next;
      bit_ptr_reg    <= bit_ptr_next;
      cfg_ready      <= (state_next == IDLE);
      busy           <= (state_next != IDLE);
      done           <= (state_next == RELEASE);
      ser_data       <= ser_data_next;
      ser_shift      <= (state_next == SHIFT);
      ser_load       <= (state_next == LOAD);
      // Hold drops on entry to HOLD and is only lifted by RELEASE.
      if (state_next == HOLD) begin
        pad_hld_n <= 1'b0;
      end else if (state_next == RELEASE) begin
        pad_hld_n <= 1'b1;
      end
      if (state_next == RELEASE) begin
        pad_enable <= 1'b1;
      end
    end
  end

  // Shadow words: reset to the default pad configuration, written when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPADS; i++) begin
        shadow[i] <= CFG_RESET;
      end
    end else if (wr_en) begin
      shadow[cfg_addr] <= cfg_data;
    end
  end

`ifdef ASIC_IORING_READBACK_EN
  // Registered shadow readback; out-of-range addresses read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (int'(rd_addr) < NPADS) begin
      rd_data <= shadow[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end
`endif

endmodule
